hazard_scoreboard: RTL and testbench

Centralised, parametrised pipeline-control tracker for the MIPS pipeline; replaces per-stage decode of write-enable with one block that decodes at D, carries (write-enable, destination, Tnew) through STAGES downstream pipeline registers, and derives stall and forwarding selects for D-stage source operands. Sits beside the D-stage register file; drives the PC/D-register stall, the E-register bubble and the forwarding muxes. The last stage's fields are the W-stage register-file write controls.

---
 rtl/hazard_scoreboard_pkg.sv | 56 +++++
 rtl/hazard_scoreboard_instr_class_decode.sv | 114 +++++++++++
 rtl/hazard_scoreboard.sv | 166 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
// Shared definitions for the MIPS hazard scoreboard and its decoder:
//   - opcode / funct constants for the decoded instruction subset
//   - Tnew / Tuse timing constants (in cycles, counted from entry to E)
//   - stage_entry_t: the {we, wa, tnew} record carried down the pipeline
//   - age_entry(): advances an entry by one stage (saturating Tnew decrement)
// The top-level REG_AW / TNEW_W parameters are expected to equal SB_REG_AW /
// SB_TNEW_W; the entry record is sized from the package values.
package hazard_scoreboard_pkg;

  localparam int SB_REG_AW = 5;
  localparam int SB_TNEW_W = 2;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // Cycles until the result exists, measured when the producer enters E
  localparam logic [SB_TNEW_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [SB_TNEW_W-1:0] TNEW_JAL  = 2'd0;
  localparam logic [SB_TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [SB_TNEW_W-1:0] TNEW_LW   = 2'd2;

  // Cycles until the consumer actually needs the operand, measured from D
  localparam logic [SB_TNEW_W-1:0] TUSE_BR  = 2'd0;
  localparam logic [SB_TNEW_W-1:0] TUSE_ALU = 2'd1;
  localparam logic [SB_TNEW_W-1:0] TUSE_ST  = 2'd2;

  localparam logic [SB_REG_AW-1:0] RA_ADDR = 5'd31;

  typedef struct packed {
    logic                 we;
    logic [SB_REG_AW-1:0] wa;
    logic [SB_TNEW_W-1:0] tnew;
  } stage_entry_t;

  function automatic stage_entry_t age_entry(input stage_entry_t e);
    stage_entry_t r;
    r = e;
    if (e.tnew != '0) r.tnew = e.tnew - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_instr_class_decode.sv
// instr_class_decode
// Purely combinational classification of one MIPS instruction into the
// scoreboard's view of it. Usable by any stage controller.
// Ports:
//   instr   in   32  instruction word
//   we      out  1   instruction writes a register (never for $0)
//   wa      out  5   destination register (0 when we=0)
//   tnew    out  2   Tnew at entry to E (0 when we=0)
//   use_rs  out  1   rs is read;  tuse_rs out 2  Tuse of rs
//   use_rt  out  1   rt is read;  tuse_rt out 2  Tuse of rt
// Unknown opcodes / functs decode as nop.
module instr_class_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [31:0]          instr,
  output logic                 we,
  output logic [SB_REG_AW-1:0] wa,
  output logic [SB_TNEW_W-1:0] tnew,
  output logic                 use_rs,
  output logic [SB_TNEW_W-1:0] tuse_rs,
  output logic                 use_rt,
  output logic [SB_TNEW_W-1:0] tuse_rt
);

  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic [SB_REG_AW-1:0] rt_f;
  logic [SB_REG_AW-1:0] rd_f;
  logic                 we_raw;
  logic [SB_REG_AW-1:0] dest;
  logic [SB_TNEW_W-1:0] tnew_raw;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign funct  = instr[5:0];

  // rs address and shamt do not influence classification
  logic unused_bits;
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    we_raw   = 1'b0;
    dest     = '0;
    tnew_raw = TNEW_NONE;
    use_rs   = 1'b0;
    tuse_rs  = '0;
    use_rt   = 1'b0;
    tuse_rt  = '0;
    unique case (opcode)
      OP_R: begin
        unique case (funct)
          FN_ADDU, FN_SUBU: begin
            we_raw   = 1'b1;
            dest     = rd_f;
            tnew_raw = TNEW_ALU;
            use_rs   = 1'b1;
            tuse_rs  = TUSE_ALU;
            use_rt   = 1'b1;
            tuse_rt  = TUSE_ALU;
          end
          FN_JR: begin
            use_rs  = 1'b1;
            tuse_rs = TUSE_BR;
          end
          default: ;  // FN_NOP and unknown functs
        endcase
      end
      OP_ORI: begin
        we_raw   = 1'b1;
        dest     = rt_f;
        tnew_raw = TNEW_ALU;
        use_rs   = 1'b1;
        tuse_rs  = TUSE_ALU;
      end
      OP_LW: begin
        we_raw   = 1'b1;
        dest     = rt_f;
        tnew_raw = TNEW_LW;
        use_rs   = 1'b1;
        tuse_rs  = TUSE_ALU;
      end
      OP_SW: begin
        use_rs  = 1'b1;
        tuse_rs = TUSE_ALU;
        use_rt  = 1'b1;
        tuse_rt = TUSE_ST;
      end
      OP_BEQ: begin
        use_rs  = 1'b1;
        tuse_rs = TUSE_BR;
        use_rt  = 1'b1;
        tuse_rt = TUSE_BR;
      end
      OP_LUI: begin
        we_raw   = 1'b1;
        dest     = rt_f;
        tnew_raw = TNEW_ALU;
      end
      OP_JAL: begin
        we_raw   = 1'b1;
        dest     = RA_ADDR;
        tnew_raw = TNEW_JAL;
      end
      default: ;  // OP_J and unknown opcodes
    endcase
  end

  // A write to $0 is architecturally void; drop it so it can never match.
  assign we   = we_raw && (dest != '0);
  assign wa   = we ? dest : '0;
  assign tnew = we ? tnew_raw : '0;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks {we, wa, tnew} of the STAGES pipeline stages after D (1 = E,
// STAGES = W) and derives the D-stage stall and forwarding selects.
// Build option: HAZARD_SCOREBOARD_FWD_EN
//   defined   - stall only when Tnew > Tuse, forward from the youngest
//               matching stage once its Tnew reaches 0
//   undefined - no forwarding; stall on any match in stages 1..STAGES-1,
//               the register file's write-first bypass covers stage STAGES
// Ports:
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous active-high, empties all stages
//   instr_d      in   32      instruction in D
//   valid_d      in   1       instr_d is real (0 = bubble)
//   stall        out  1       hold PC/D, bubble into E (combinational)
//   fwd_rs_sel   out  SEL_W   rs source: 0 = regfile, k = stage k
//   fwd_rt_sel   out  SEL_W   rt source, same encoding
//   reg_write_w  out  1       write enable of stage STAGES
//   wa_w         out  REG_AW  write address of stage STAGES
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter  int STAGES = 3,
  parameter  int REG_AW = 5,
  parameter  int TNEW_W = 2,
  localparam int SEL_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_d,
  input  logic              valid_d,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              reg_write_w,
  output logic [REG_AW-1:0] wa_w
);

  // ---------------- decode of the D instruction ----------------
  logic                 dec_we;
  logic [SB_REG_AW-1:0] dec_wa;
  logic [SB_TNEW_W-1:0] dec_tnew;
  logic                 dec_use_rs;
  logic [SB_TNEW_W-1:0] dec_tuse_rs;
  logic                 dec_use_rt;
  logic [SB_TNEW_W-1:0] dec_tuse_rt;

  instr_class_decode u_decode (
    .instr   (instr_d),
    .we      (dec_we),
    .wa      (dec_wa),
    .tnew    (dec_tnew),
    .use_rs  (dec_use_rs),
    .tuse_rs (dec_tuse_rs),
    .use_rt  (dec_use_rt),
    .tuse_rt (dec_tuse_rt)
  );

  stage_entry_t dec_entry;
  assign dec_entry = '{we: dec_we, wa: dec_wa, tnew: dec_tnew};

  logic [SB_REG_AW-1:0] rs_addr;
  logic [SB_REG_AW-1:0] rt_addr;
  assign rs_addr = instr_d[25:21];
  assign rt_addr = instr_d[20:16];

  // Operands reading $0 or not read at all never create a hazard.
  logic rs_need;
  logic rt_need;
  assign rs_need = valid_d && dec_use_rs && (rs_addr != '0);
  assign rt_need = valid_d && dec_use_rt && (rt_addr != '0);

  // ---------------- stage registers ----------------
  stage_entry_t stage_q [1:STAGES];
  stage_entry_t stage_d [1:STAGES];

  // ---------------- per-stage address match ----------------
  logic [STAGES:1] rs_hit;
  logic [STAGES:1] rt_hit;

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_hit
      assign rs_hit[gi] = stage_q[gi].we && (stage_q[gi].wa == rs_addr);
      assign rt_hit[gi] = stage_q[gi].we && (stage_q[gi].wa == rt_addr);
    end
  endgenerate

  // Youngest match wins: scan oldest to youngest so the last hit written
  // is the smallest stage index.
  logic              rs_found;
  logic [SEL_W-1:0]  rs_k;
  logic [TNEW_W-1:0] rs_tnew;
  logic              rt_found;
  logic [SEL_W-1:0]  rt_k;
  logic [TNEW_W-1:0] rt_tnew;

  always_comb begin
    rs_found = 1'b0;
    rs_k     = '0;
    rs_tnew  = '0;
    rt_found = 1'b0;
    rt_k     = '0;
    rt_tnew  = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (rs_hit[k]) begin
        rs_found = 1'b1;
        rs_k     = SEL_W'(k);
        rs_tnew  = TNEW_W'(stage_q[k].tnew);
      end
      if (rt_hit[k]) begin
        rt_found = 1'b1;
        rt_k     = SEL_W'(k);
        rt_tnew  = TNEW_W'(stage_q[k].tnew);
      end
    end
  end

  // ---------------- hazard resolution ----------------
  logic rs_stall;
  logic rt_stall;

`ifdef HAZARD_SCOREBOARD_FWD_EN
  always_comb begin
    rs_stall   = rs_need && rs_found && (rs_tnew > TNEW_W'(dec_tuse_rs));
    rt_stall   = rt_need && rt_found && (rt_tnew > TNEW_W'(dec_tuse_rt));
    fwd_rs_sel = (rs_need && rs_found && (rs_tnew == '0)) ? rs_k : '0;
    fwd_rt_sel = (rt_need && rt_found && (rt_tnew == '0)) ? rt_k : '0;
  end
`else
  localparam logic [SEL_W-1:0] LAST_STAGE = SEL_W'(STAGES);

  // If the youngest match is not the last stage, some match lies in
  // 1..STAGES-1 and the value cannot be obtained from the register file yet.
  always_comb begin
    rs_stall   = rs_need && rs_found && (rs_k != LAST_STAGE);
    rt_stall   = rt_need && rt_found && (rt_k != LAST_STAGE);
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
  end

  logic unused_fwd;
  assign unused_fwd = ^{rs_tnew, rt_tnew, dec_tuse_rs, dec_tuse_rt};
`endif

  assign stall = rs_stall || rt_stall;

  // ---------------- pipeline advance ----------------
  always_comb begin
    stage_d[1] = (valid_d && !stall) ? dec_entry : '0;
    for (int k = 2; k <= STAGES; k++) begin
      stage_d[k] = age_entry(stage_q[k-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign reg_write_w = stage_q[STAGES].we;
  assign wa_w        = REG_AW'(stage_q[STAGES].wa);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES=3). The driver walks a table of
// per-cycle D-stage inputs, pushing each row's expected outputs into a queue;
// a monitor on the falling edge pops and compares. Expected values for both
// builds (with and without HAZARD_SCOREBOARD_FWD_EN) are hand-derived.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        stall;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic        reg_write_w;
  logic [4:0]  wa_w;

  always #5 clk = ~clk;

  hazard_scoreboard #(.STAGES(3), .REG_AW(5), .TNEW_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_d     (instr_d),
    .valid_d     (valid_d),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .reg_write_w (reg_write_w),
    .wa_w        (wa_w)
  );

  typedef struct {
    int          idx;
    string       tag;
    logic        rst;
    logic        vld;
    logic [31:0] ins;
    logic        chk;
    logic        st;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic        we;
    logic [4:0]  wa;
  } vec_t;

  vec_t  vecs[$];
  vec_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op,
                                        input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ---------------- table builders ----------------
  task automatic add(input logic rst, vld, input logic [31:0] ins,
                     input logic chk, st, input logic [1:0] rs, rt,
                     input logic we, input logic [4:0] wa);
    vec_t v;
    v.idx = vecs.size(); v.tag = cur_tag;
    v.rst = rst; v.vld = vld; v.ins = ins; v.chk = chk;
    v.st = st; v.rs = rs; v.rt = rt; v.we = we; v.wa = wa;
    vecs.push_back(v);
  endtask

  // valid instruction in D
  task automatic vi(input logic [31:0] ins, input logic st,
                    input logic [1:0] rs, rt, input logic we,
                    input logic [4:0] wa);
    add(1'b0, 1'b1, ins, 1'b1, st, rs, rt, we, wa);
  endtask

  // bubble in D: no stall, no forwarding, only the W-stage view varies
  task automatic vb(input logic we, input logic [4:0] wa);
    add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 2'd0, we, wa);
  endtask

  // ---------------- comparison ----------------
  task automatic cmp(input string tag, input string fld, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s vec %0d: got %0h expected %0h", tag, fld, idx, got, exp);
    end
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        cmp(e.tag, "stall",       e.idx, 32'(stall),       32'(e.st));
        cmp(e.tag, "fwd_rs_sel",  e.idx, 32'(fwd_rs_sel),  32'(e.rs));
        cmp(e.tag, "fwd_rt_sel",  e.idx, 32'(fwd_rt_sel),  32'(e.rt));
        cmp(e.tag, "reg_write_w", e.idx, 32'(reg_write_w), 32'(e.we));
        cmp(e.tag, "wa_w",        e.idx, 32'(wa_w),        32'(e.wa));
        $display("vec %0d %s: instr=%h valid=%0b stall=%0b rs_sel=%0d rt_sel=%0d we_w=%0b wa_w=%0d",
                 e.idx, e.tag, e.ins, e.vld, stall, fwd_rs_sel, fwd_rt_sel, reg_write_w, wa_w);
      end
    end
  end

  // ---------------- stimulus table ----------------
  task automatic build();
    logic [31:0] addu3, subu4, addu5, lw5, addu6, addu9, lw7, beq7, jal_i, jr31;
    logic [31:0] ori0, addu2, unk, lui8, ori8, addu10, addu11, lw12, sw12;
    addu3  = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    subu4  = rtype(5'd3, 5'd3, 5'd4, 6'h23);
    addu5  = rtype(5'd3, 5'd3, 5'd5, 6'h21);
    lw5    = itype(6'h23, 5'd0, 5'd5, 16'h0000);
    addu6  = rtype(5'd5, 5'd0, 5'd6, 6'h21);
    addu9  = rtype(5'd5, 5'd0, 5'd9, 6'h21);
    lw7    = itype(6'h23, 5'd0, 5'd7, 16'h0000);
    beq7   = itype(6'h04, 5'd7, 5'd0, 16'h0004);
    jal_i  = {6'h03, 26'h0000100};
    jr31   = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    ori0   = itype(6'h0D, 5'd1, 5'd0, 16'h0005);
    addu2  = rtype(5'd0, 5'd0, 5'd2, 6'h21);
    unk    = itype(6'h3F, 5'd2, 5'd2, 16'h0000);
    lui8   = itype(6'h0F, 5'd0, 5'd8, 16'h1234);
    ori8   = itype(6'h0D, 5'd8, 5'd8, 16'h0001);
    addu10 = rtype(5'd8, 5'd8, 5'd10, 6'h21);
    addu11 = rtype(5'd8, 5'd0, 5'd11, 6'h21);
    lw12   = itype(6'h23, 5'd0, 5'd12, 16'h0000);
    sw12   = itype(6'h2B, 5'd0, 5'd12, 16'h0004);

    cur_tag = "reset";
    add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 5'd0);
    vb(1'b0, 5'd0);

`ifdef HAZARD_SCOREBOARD_FWD_EN
    cur_tag = "alu_b2b";
    vi(addu3, 0, 0, 0, 0, 0); vi(subu4, 0, 0, 0, 0, 0); vi(addu5, 0, 2, 2, 0, 0);
    vb(1, 3); vb(1, 4); vb(1, 5); vb(0, 0);
    cur_tag = "load_use";
    vi(lw5, 0, 0, 0, 0, 0); vi(addu6, 1, 0, 0, 0, 0); vi(addu6, 0, 0, 0, 0, 0);
    vi(addu9, 0, 3, 0, 1, 5); vb(0, 0); vb(1, 6); vb(1, 9); vb(0, 0);
    cur_tag = "br_after_ld";
    vi(lw7, 0, 0, 0, 0, 0); vi(beq7, 1, 0, 0, 0, 0); vi(beq7, 1, 0, 0, 0, 0);
    vi(beq7, 0, 3, 0, 1, 7); vb(0, 0);
    cur_tag = "jal_jr";
    vi(jal_i, 0, 0, 0, 0, 0); vi(jr31, 0, 1, 0, 0, 0); vb(0, 0); vb(1, 31); vb(0, 0);
`else
    cur_tag = "alu_b2b";
    vi(addu3, 0, 0, 0, 0, 0); vi(subu4, 1, 0, 0, 0, 0); vi(subu4, 1, 0, 0, 0, 0);
    vi(subu4, 0, 0, 0, 1, 3); vi(addu5, 0, 0, 0, 0, 0);
    vb(0, 0); vb(1, 4); vb(1, 5); vb(0, 0);
    cur_tag = "load_use";
    vi(lw5, 0, 0, 0, 0, 0); vi(addu6, 1, 0, 0, 0, 0); vi(addu6, 1, 0, 0, 0, 0);
    vi(addu6, 0, 0, 0, 1, 5); vi(addu9, 0, 0, 0, 0, 0);
    vb(0, 0); vb(1, 6); vb(1, 9); vb(0, 0);
    cur_tag = "br_after_ld";
    vi(lw7, 0, 0, 0, 0, 0); vi(beq7, 1, 0, 0, 0, 0); vi(beq7, 1, 0, 0, 0, 0);
    vi(beq7, 0, 0, 0, 1, 7); vb(0, 0);
    cur_tag = "jal_jr";
    vi(jal_i, 0, 0, 0, 0, 0); vi(jr31, 1, 0, 0, 0, 0); vi(jr31, 1, 0, 0, 0, 0);
    vi(jr31, 0, 0, 0, 1, 31); vb(0, 0);
`endif

    cur_tag = "zero_reg";
    vi(ori0, 0, 0, 0, 0, 0); vi(addu2, 0, 0, 0, 0, 0); vi(unk, 0, 0, 0, 0, 0);
    vb(0, 0); vb(1, 2); vb(0, 0);

`ifdef HAZARD_SCOREBOARD_FWD_EN
    cur_tag = "two_writers";
    vi(lui8, 0, 0, 0, 0, 0); vi(ori8, 0, 0, 0, 0, 0); vi(addu10, 0, 0, 0, 0, 0);
    vi(addu11, 0, 2, 0, 1, 8); vb(1, 8); vb(1, 10); vb(1, 11); vb(0, 0);
    cur_tag = "lw_sw";
    vi(lw12, 0, 0, 0, 0, 0); vi(sw12, 0, 0, 0, 0, 0); vb(0, 0); vb(1, 12); vb(0, 0);
`else
    cur_tag = "two_writers";
    vi(lui8, 0, 0, 0, 0, 0); vi(ori8, 1, 0, 0, 0, 0); vi(ori8, 1, 0, 0, 0, 0);
    vi(ori8, 0, 0, 0, 1, 8); vi(addu10, 1, 0, 0, 0, 0); vi(addu10, 1, 0, 0, 0, 0);
    vi(addu10, 0, 0, 0, 1, 8); vi(addu11, 0, 0, 0, 0, 0);
    vb(0, 0); vb(1, 10); vb(1, 11); vb(0, 0);
    cur_tag = "lw_sw";
    vi(lw12, 0, 0, 0, 0, 0); vi(sw12, 1, 0, 0, 0, 0); vi(sw12, 1, 0, 0, 0, 0);
    vi(sw12, 0, 0, 0, 1, 12); vb(0, 0);
`endif

    // Reset while a load-use stall is showing: the stall is visible in that
    // cycle, then the held addu is re-evaluated against empty stages.
    cur_tag = "reset_mid_stall";
    vi(lw5, 0, 0, 0, 0, 0);
    add(1'b1, 1'b1, addu6, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 5'd0);
    vi(addu6, 0, 0, 0, 0, 0); vb(0, 0); vb(0, 0); vb(1, 6); vb(0, 0);
  endtask

  // ---------------- driver ----------------
  initial begin
    reset   = 1'b1;
    valid_d = 1'b0;
    instr_d = 32'h0;
    build();
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset   = vecs[i].rst;
      valid_d = vecs[i].vld;
      instr_d = vecs[i].ins;
      exp_q.push_back(vecs[i]);
    end
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
